// File: rtl/rename_alloc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rename_alloc_ctrl_if
// Description : Dispatch, commit and free-list signal bundle for the rename
//               allocation controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface rename_alloc_ctrl_if #(
  parameter int PR_WIDTH = 6,
  parameter int AR_WIDTH = 5
);
  // dispatch side
  logic                disp_valid;
  logic [AR_WIDTH-1:0] disp_rd;
  logic                disp_ready;
  logic [PR_WIDTH-1:0] alloc_preg;
  // commit / flush side
  logic                commit_valid;
  logic [PR_WIDTH-1:0] commit_old_preg;
  logic                flush;
  // free list side
  logic                fl_is_empty;
  logic [PR_WIDTH-1:0] fl_free_preg;
  logic                fl_dequeue;
  logic                fl_enqueue;
  logic [PR_WIDTH-1:0] fl_freed_preg;
  logic                fl_branch;
  logic                fl_jmp;
  // status
  logic                recovering;
  logic [31:0]         stall_empty_cnt;
  logic [15:0]         flush_cnt;

  // Environment side: pipeline and free list
  modport master (
    output disp_valid, disp_rd, commit_valid, commit_old_preg, flush,
           fl_is_empty, fl_free_preg,
    input  disp_ready, alloc_preg, fl_dequeue, fl_enqueue, fl_freed_preg,
           fl_branch, fl_jmp, recovering, stall_empty_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  disp_valid, disp_rd, commit_valid, commit_old_preg, flush,
           fl_is_empty, fl_free_preg,
    output disp_ready, alloc_preg, fl_dequeue, fl_enqueue, fl_freed_preg,
           fl_branch, fl_jmp, recovering, stall_empty_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/rename_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rename_alloc_ctrl
// Description : Grants destination physical registers to dispatch, returns
//               freed registers from commit, converts flushes into free-list
//               branch/jump recovery, holds dispatch for a recovery window and
//               keeps saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module rename_alloc_ctrl #(
  parameter int PR_WIDTH       = 6,
  parameter int AR_WIDTH       = 5,
  parameter int RECOVER_CYCLES = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  rename_alloc_ctrl_if.slave    bus
);

  localparam logic [1:0] c_ST_INIT    = 2'd0;
  localparam logic [1:0] c_ST_RUN     = 2'd1;
  localparam logic [1:0] c_ST_RECOVER = 2'd2;

  // Recovery window counts down to zero while in RECOVER, so load one less
  localparam logic [3:0]          c_REC_LOAD = 4'(RECOVER_CYCLES - 1);
  localparam logic [AR_WIDTH-1:0] c_AR_ZERO  = '0;
  localparam logic [PR_WIDTH-1:0] c_PR_ZERO  = '0;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [3:0]          r_rec_cnt;
  logic [3:0]          w_rec_cnt_nxt;
  logic [31:0]         r_stall_empty_cnt;
  logic [15:0]         r_flush_cnt;

  logic                w_rd_is_x0;
  logic                w_run_open;
  logic                w_disp_ready;
  logic [PR_WIDTH-1:0] w_alloc_preg;
  logic                w_fl_dequeue;
  logic                w_fl_enqueue;
  logic [PR_WIDTH-1:0] w_fl_freed_preg;
  logic                w_fl_branch;
  logic                w_fl_jmp;
  logic                w_recovering;
  logic                w_stall_empty;

  assign w_rd_is_x0 = (bus.disp_rd == c_AR_ZERO);

  // State register with recovery countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_ST_INIT;
      r_rec_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_rec_cnt <= w_rec_cnt_nxt;
    end
  end

  // Next-state: any flush (re)enters RECOVER with a fresh window
  always_comb begin
    w_state_nxt   = r_state;
    w_rec_cnt_nxt = r_rec_cnt;
    if (bus.flush) begin
      w_state_nxt   = c_ST_RECOVER;
      w_rec_cnt_nxt = c_REC_LOAD;
    end else begin
      case (r_state)
        c_ST_INIT: w_state_nxt = c_ST_RUN;
        c_ST_RUN:  w_state_nxt = c_ST_RUN;
        c_ST_RECOVER: begin
          if (r_rec_cnt == 4'd0) begin
            w_state_nxt = c_ST_RUN;
          end else begin
            w_rec_cnt_nxt = r_rec_cnt - 4'd1;
          end
        end
        default: w_state_nxt = c_ST_INIT;
      endcase
    end
  end

  // Outputs: grant path, commit return and flush recovery commands, all
  // forced to their idle values while rst is asserted
  always_comb begin
    w_run_open      = 1'b0;
    w_disp_ready    = 1'b0;
    w_alloc_preg    = c_PR_ZERO;
    w_fl_dequeue    = 1'b0;
    w_fl_enqueue    = 1'b0;
    w_fl_freed_preg = c_PR_ZERO;
    w_fl_branch     = 1'b0;
    w_fl_jmp        = 1'b0;
    w_recovering    = 1'b1;
    w_stall_empty   = 1'b0;
    if (!rst) begin
      w_run_open    = (r_state == c_ST_RUN) && !bus.flush;
      w_disp_ready  = w_run_open && (w_rd_is_x0 || !bus.fl_is_empty);
      w_alloc_preg  = w_rd_is_x0 ? c_PR_ZERO : bus.fl_free_preg;
      w_fl_dequeue  = bus.disp_valid && w_disp_ready && !w_rd_is_x0;
      w_stall_empty = bus.disp_valid && w_run_open && !w_rd_is_x0 && bus.fl_is_empty;
      w_recovering  = (r_state != c_ST_RUN);
      if (bus.flush) begin
        // The commit rides along with the jump so the committed head stays exact
        w_fl_jmp    = bus.commit_valid;
        w_fl_branch = !bus.commit_valid;
        if (bus.commit_valid) begin
          w_fl_freed_preg = bus.commit_old_preg;
        end
      end else if (bus.commit_valid && (bus.commit_old_preg != c_PR_ZERO)) begin
        w_fl_enqueue    = 1'b1;
        w_fl_freed_preg = bus.commit_old_preg;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_empty_cnt <= 32'd0;
      r_flush_cnt       <= 16'd0;
    end else begin
      if (w_stall_empty && (r_stall_empty_cnt != 32'hFFFF_FFFF)) begin
        r_stall_empty_cnt <= r_stall_empty_cnt + 32'd1;
      end
      if (bus.flush && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign bus.disp_ready      = w_disp_ready;
  assign bus.alloc_preg      = w_alloc_preg;
  assign bus.fl_dequeue      = w_fl_dequeue;
  assign bus.fl_enqueue      = w_fl_enqueue;
  assign bus.fl_freed_preg   = w_fl_freed_preg;
  assign bus.fl_branch       = w_fl_branch;
  assign bus.fl_jmp          = w_fl_jmp;
  assign bus.recovering      = w_recovering;
  assign bus.stall_empty_cnt = r_stall_empty_cnt;
  assign bus.flush_cnt       = r_flush_cnt;

endmodule
`default_nettype wire

// File: doc/rename_alloc_ctrl.md
# rename_alloc_ctrl

Sequencing controller between the rename/dispatch stage, the ROB commit port and the physical-register free list. It grants destination physical registers to dispatch, routes freed registers from commit, and turns pipeline flushes into the free list's branch or jump (commit + flush) recovery commands. After every flush it holds dispatch for a fixed recovery window, and it keeps saturating performance counters.

## Interface
- PR_WIDTH, 6, physical register index width
- AR_WIDTH, 5, architectural register index width
- RECOVER_CYCLES, 1, dispatch-blocked cycles after a flush (legal range 1–15)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- disp_valid  in  1  dispatch requests a rename
- disp_rd  in  AR_WIDTH  architectural destination of the request
- disp_ready  out  1  request accepted this cycle
- alloc_preg  out  PR_WIDTH  physical register granted; valid when disp_valid && disp_ready
- commit_valid  in  1  ROB commits one instruction (never stalled)
- commit_old_preg  in  PR_WIDTH  previous mapping of the committed rd, to be freed; 0 means none
- flush  in  1  single-cycle pipeline flush request
- fl_is_empty  in  1  free list empty
- fl_free_preg  in  PR_WIDTH  free list head entry
- fl_dequeue  out  1  pop free list
- fl_enqueue  out  1  push fl_freed_preg
- fl_freed_preg  out  PR_WIDTH  register returned to free list
- fl_branch  out  1  free list flush (restore head)
- fl_jmp  out  1  free list commit + flush
- recovering  out  1  state != RUN
- stall_empty_cnt  out  32  cycles with disp_valid high and the request blocked by an empty free list, saturating
- flush_cnt  out  16  flushes issued, saturating

## Operation
- State machine has three states: INIT, RUN, RECOVER. rst forces INIT, rec_cnt=0 and both counters to 0.
- INIT -> RUN unconditionally after one cycle. This holds dispatch for the cycle after rst deasserts.
- RUN -> RECOVER on flush. rec_cnt loads RECOVER_CYCLES-1.
- RECOVER -> RUN when rec_cnt==0 and no flush. Otherwise rec_cnt decrements.
- A flush while in RECOVER or INIT re-issues the free list command, enters RECOVER and reloads rec_cnt.
- disp_ready = (state==RUN) && !flush && (disp_rd==0 || !fl_is_empty).
- alloc_preg = (disp_rd==0) ? 0 : fl_free_preg. This path is combinational.
- fl_dequeue = disp_valid && disp_ready && disp_rd!=0. An x0 destination never consumes a register.
- Commit handling:
  - Commit without flush: fl_enqueue = commit_valid && commit_old_preg!=0, with fl_freed_preg = commit_old_preg.
  - Commit with old preg 0: no enqueue.
- Flush handling:
  - flush && commit_valid: fl_jmp=1 and fl_freed_preg=commit_old_preg, even when that value is 0; the free list handles the x0 case. fl_enqueue=0 and fl_branch=0.
  - flush && !commit_valid: fl_branch=1, fl_enqueue=0, fl_jmp=0.
  - Commits are never deferred across a flush. Merging the commit into fl_jmp keeps the free list's committed head pointer exact.
- Commits are accepted in every state, including INIT and RECOVER.
- fl_enqueue and fl_dequeue may assert in the same cycle.
- fl_branch and fl_jmp are mutually exclusive. Neither asserts together with fl_dequeue.
- stall_empty_cnt increments when disp_valid && state==RUN && !flush && disp_rd!=0 && fl_is_empty. It holds at 0xFFFFFFFF.
- flush_cnt increments on every flush cycle. It holds at 0xFFFF.
- When fl_freed_preg is not in use it drives 0.

## Timing
- Reset values: disp_ready=0, alloc_preg=0, fl_dequeue=0, fl_enqueue=0, fl_freed_preg=0, fl_branch=0, fl_jmp=0, recovering=1, stall_empty_cnt=0, flush_cnt=0. The combinational outputs hold these values during rst.
- Grant latency is 0 cycles: request, grant and fl_dequeue fall in the same cycle. The free list head advances at the next edge.
- Flush in cycle T:
  - fl_branch or fl_jmp asserts in T.
  - disp_ready is 0 for T through T+RECOVER_CYCLES.
  - The first grant is possible in T+RECOVER_CYCLES+1.
- A flush in cycle T while rst is high is ignored; rst has priority over everything.
- All state and counters update on posedge clk only.

## Test plan
- Reset, then disp_valid=1, disp_rd=5 held → disp_ready=0 in the first post-reset cycle, 1 in the next. alloc_preg=fl_free_preg (32 after free-list reset) and fl_dequeue=1 in that cycle.
- fl_is_empty=1, requests with disp_rd=3 for 4 cycles, then disp_rd=0 → disp_ready=0 for 4 cycles and stall_empty_cnt=4. The x0 request is granted with alloc_preg=0 and fl_dequeue=0.
- commit_valid=1 with commit_old_preg=40, same cycle as a grant → fl_enqueue=1, fl_freed_preg=40 and fl_dequeue=1 together. commit_old_preg=0 → fl_enqueue=0.
- flush with commit_valid=1 and commit_old_preg=45 → fl_jmp=1, fl_freed_preg=45, fl_enqueue=0, fl_branch=0. flush alone → fl_branch=1. flush_cnt increments by 1 each time.
- RECOVER_CYCLES=3, flush at T → disp_ready=0 for T..T+3 and 1 at T+4. A second flush at T+2 moves the reopen to T+6.
- Force flush_cnt to 0xFFFF and flush again → it stays 0xFFFF. Assert rst mid-RECOVER → the next cycle is INIT with all counters at 0.
